mux_n_pipe: RTL
===============

MUX_N_PIPE -- requirements
Module: mux_n_pipe

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 32: width of each data input and of Out.
REQ-002 SHALL have parameter N_IN, default 4: number of data inputs; legal range 2..64.
REQ-003 SHALL derive localparam SEL_W = max(1, clog2(N_IN)): the sel width.
REQ-004 SHALL have port CLK  input  1: the single clock, rising edge.
REQ-005 SHALL have port RST  input  1: reset, synchronous and active-high.
REQ-006 SHALL have port sel  input  SEL_W: input index, sampled on accept.
REQ-007 SHALL have port IN_BUS  input  N_IN*IN_WIDTH, signed: input k occupies bits [k*IN_WIDTH +: IN_WIDTH].
REQ-008 SHALL have port in_valid  input  1: the upstream sel/IN_BUS pair is valid.
REQ-009 SHALL have port in_ready  output  1: the block can accept the pair.
REQ-010 SHALL have port Out  output  IN_WIDTH, signed: the selected data at the queue head.
REQ-011 SHALL have port out_valid  output  1: Out is valid.
REQ-012 SHALL have port out_ready  input  1: downstream consumes Out.
REQ-013 SHALL have port sel_err  output  1: the head entry was captured with sel >= N_IN.

Function
REQ-014 SHALL accept a pair on a rising edge when in_valid && in_ready; the captured value is IN_BUS slice sel, or slice 0 if sel >= N_IN.
REQ-015 SHALL store a per-entry error bit, set when sel >= N_IN at capture; sel_err shows the head entry's bit and is 0 when out_valid=0.
REQ-016 SHALL buffer results in a 2-entry FIFO (head + skid), using states EMPTY, ONE, FULL.
REQ-017 SHALL drive out_valid = (state != EMPTY) and in_ready = (state != FULL), both decoded from registered state only, with no combinational path from any input.
REQ-018 SHALL have 1-cycle latency: a pair accepted at edge t appears on Out with out_valid=1 after edge t when the FIFO was EMPTY.
REQ-019 SHALL pop the head when out_valid && out_ready.
REQ-020 SHALL make these transitions: EMPTY+push -> ONE; ONE+push only -> FULL; ONE+pop only -> EMPTY; ONE+push+pop -> ONE, with the new pair becoming head; FULL+pop -> ONE, with the skid entry moving to head; FULL+push is impossible because in_ready=0.
REQ-021 SHALL preserve FIFO order; no entry is dropped or duplicated.
REQ-022 SHALL hold Out and sel_err stable while out_valid && !out_ready.
REQ-023 SHALL leave Out at its last value when EMPTY, and never make it X.
REQ-024 SHALL pass data unmodified; no sign extension or truncation, since all slices are IN_WIDTH wide.
REQ-025 SHALL ignore in_valid when in_ready=0 and ignore out_ready when out_valid=0.

Reset
REQ-026 SHALL, on RST=1 at a rising edge, force state=EMPTY, Out=0, both error bits=0, and both data entries=0.
REQ-027 SHALL give RST priority over a simultaneous push or pop; an in-flight entry is discarded.
REQ-028 SHALL drive in_ready=1 from the first edge after RST deasserts, and out_valid=0 until the first accept.

Structure
REQ-029 SHALL place the state encoding (EMPTY=2'b00, ONE=2'b01, FULL=2'b10) as constants in shared package mux_pkg.
REQ-030 SHALL instantiate one combinational sub-module, mux_n_sel (parameters IN_WIDTH, N_IN; out-of-range sel selects slice 0 and raises an err output); all registers live in mux_n_pipe.
REQ-031 SHALL use no clock gating, no latches, and a single always block per register group.

Verification
REQ-032 SHALL cover single transfer: N_IN=4, IN_BUS={-4,3,2,1}, sel=2, in_valid=1 one cycle, out_ready=1 -> next cycle Out=3, out_valid=1, sel_err=0, then out_valid=0.
REQ-033 SHALL cover backpressure: out_ready=0, push sel=0 then sel=3 -> in_ready=0 after the second accept, Out holds 1; raise out_ready -> Out=1 then -4, then out_valid=0.
REQ-034 SHALL cover streaming: in_valid=1 and out_ready=1 every cycle for 8 pairs with sel=0..3 repeating -> 8 results in order, one per cycle, state stays ONE.
REQ-035 SHALL cover out-of-range sel: N_IN=3, sel=3, IN_BUS slice 0=0x55 -> Out=0x55, sel_err=1 for that entry only.
REQ-036 SHALL cover reset mid-operation: FIFO FULL, RST=1 for one edge with in_valid=1 and out_ready=1 -> out_valid=0, Out=0, sel_err=0, and in_ready=1 on the next edge.
REQ-037 SHALL cover a width sweep: IN_WIDTH=8 and N_IN=2, with IN_BUS slice 1=8'h80 and sel=1 -> Out=8'h80 (-128), no extension.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared constants for the mux_n_pipe block: FIFO state encoding and sel width helper.
package mux_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b10
  } state_t;

  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_n_sel.sv
// Combinational N-way selector; an out-of-range sel picks slice 0 and flags err.
module mux_n_sel
  import mux_pkg::*;
#(
  parameter int IN_WIDTH = 32,
  parameter int N_IN     = 4,
  localparam int SEL_W   = sel_width(N_IN)
) (
  input  logic [SEL_W-1:0]         sel,
  input  logic [N_IN*IN_WIDTH-1:0] in_bus,
  output logic [IN_WIDTH-1:0]      data,
  output logic                     err
);

  // Matching by equality avoids a constant range compare when N_IN is a power of two.
  always_comb begin
    data = in_bus[IN_WIDTH-1:0];
    err  = 1'b1;
    for (int unsigned k = 0; k < N_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        data = in_bus[k*IN_WIDTH +: IN_WIDTH];
        err  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mux_n_pipe.sv
// Registered N-way mux feeding a 2-entry (head + skid) FIFO with valid/ready handshakes.
module mux_n_pipe
  import mux_pkg::*;
#(
  parameter int IN_WIDTH = 32,
  parameter int N_IN     = 4,
  localparam int SEL_W   = sel_width(N_IN)
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic [SEL_W-1:0]                sel,
  input  logic signed [N_IN*IN_WIDTH-1:0] IN_BUS,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic signed [IN_WIDTH-1:0]      Out,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            sel_err
);

  state_t state, next_state;

  logic [IN_WIDTH-1:0] head_data, skid_data, mux_data;
  logic                head_err, skid_err, mux_err;
  logic                push, pop;

  mux_n_sel #(
    .IN_WIDTH (IN_WIDTH),
    .N_IN     (N_IN)
  ) u_sel (
    .sel    (sel),
    .in_bus (IN_BUS),
    .data   (mux_data),
    .err    (mux_err)
  );

  assign out_valid = (state != EMPTY);
  assign in_ready  = (state != FULL);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign Out       = head_data;
  assign sel_err   = head_err && out_valid;

  always_ff @(posedge CLK) begin
    if (RST) state <= EMPTY;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      EMPTY: if (push) next_state = ONE;
      ONE: begin
        if (push && !pop)      next_state = FULL;
        else if (!push && pop) next_state = EMPTY;
      end
      FULL:  if (pop) next_state = ONE;
      default: next_state = EMPTY;
    endcase
  end

  // Head is only rewritten on push-into-empty, push+pop, or skid promotion, so Out holds otherwise.
  always_ff @(posedge CLK) begin
    if (RST) begin
      head_data <= '0;
      skid_data <= '0;
      head_err  <= 1'b0;
      skid_err  <= 1'b0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (push) begin
            head_data <= mux_data;
            head_err  <= mux_err;
          end
        end
        ONE: begin
          if (push && pop) begin
            head_data <= mux_data;
            head_err  <= mux_err;
          end else if (push) begin
            skid_data <= mux_data;
            skid_err  <= mux_err;
          end
        end
        FULL: begin
          if (pop) begin
            head_data <= skid_data;
            head_err  <= skid_err;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
